// File: rtl/fsb16_target.sv
// FSB16 slave endpoint: decodes the two address frames from the bridge, runs one
// request/acknowledge access on the peripheral register bus, and returns a
// one-cycle registered response (rdy_n / error_n / read data). Also registers the
// peripheral interrupt out as irq_n.
module fsb16_target #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aen,
    input  logic        size,
    input  logic        wr_n,
    input  logic [15:0] AD_in,
    output logic [15:0] AD_out,
    output logic        ad_oe,
    output logic        rdy_n,
    output logic        error_n,
    output logic        irq_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_be,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic        irq
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_TURN,
        ST_WDATA,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rdy_n_q, rdy_n_d;
    logic        error_n_q, error_n_d;
    logic        irq_n_q, irq_n_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [1:0]  bus_be_q, bus_be_d;
    logic [15:0] bus_wdata_q, bus_wdata_d;

    logic        hit;
    logic [1:0]  be_sel;
    logic [7:0]  cnt_inc;

    assign hit     = ((addr_q & ADDR_MASK) == BASE_ADDR);
    assign be_sel  = size_q ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);
    assign cnt_inc = cnt_q + 8'd1;

    // Next-state and registered-output computation; responses are loaded on the
    // transition into RESP so they appear exactly during the RESP cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        rdy_n_d     = 1'b1;
        error_n_d   = 1'b1;
        irq_n_d     = ~irq;
        ad_oe_d     = 1'b0;
        ad_out_d    = '0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (aen) begin
                    addr_d[15:0] = AD_in;
                    we_d         = wr_n;
                    size_d       = size;
                    state_d      = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: begin
                if (aen) begin
                    addr_d[31:16] = AD_in;
                    state_d       = we_q ? ST_WDATA : ST_TURN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN, ST_WDATA: begin
                if (state_q == ST_WDATA) begin
                    bus_wdata_d = AD_in;
                end
                if (hit) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = we_q;
                    bus_addr_d = addr_q;
                    bus_be_d   = be_sel;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end else begin
                    rdy_n_d   = 1'b0;
                    error_n_d = 1'b0;
                    ad_oe_d   = ~we_q;
                    state_d   = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    rdy_n_d   = 1'b0;
                    error_n_d = ~bus_err;
                    ad_oe_d   = ~we_q;
                    if (!we_q && !bus_err) begin
                        ad_out_d = bus_rdata;
                    end
                    state_d = ST_RESP;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    bus_req_d = 1'b0;
                    rdy_n_d   = 1'b0;
                    error_n_d = 1'b0;
                    ad_oe_d   = ~we_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears bus_req immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            cnt_q       <= '0;
            rdy_n_q     <= 1'b1;
            error_n_q   <= 1'b1;
            irq_n_q     <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            rdy_n_q     <= rdy_n_d;
            error_n_q   <= error_n_d;
            irq_n_q     <= irq_n_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign AD_out    = ad_out_q;
    assign ad_oe     = ad_oe_q;
    assign rdy_n     = rdy_n_q;
    assign error_n   = error_n_q;
    assign irq_n     = irq_n_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_fsb16_target.sv
// Bench for fsb16_target: directed scenarios plus randomized transfers checked
// against a transaction-level model of the endpoint.
module tb_fsb16_target;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;
    localparam int          TMO  = 6;
    localparam int          NCYC = TMO + 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        aen, size, wr_n;
    logic [15:0] AD_in, AD_out;
    logic        ad_oe, rdy_n, error_n, irq_n;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata, bus_rdata;
    logic        bus_ack, bus_err, irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          rdy_cyc;
        int          rdy_cnt;
        int          req_cnt;
        int          req_first;
        logic [15:0] ad;
        logic        oe;
        logic        errn;
        logic [31:0] ba;
        logic [1:0]  be;
        logic        bwe;
        logic [15:0] bwd;
        int          unstable;
        int          idle_bad;
    } obs_t;

    typedef struct {
        int          rdy_cyc;
        int          req_cnt;
        logic [15:0] ad;
        logic        oe;
        logic        errn;
        logic [1:0]  be;
    } exp_t;

    fsb16_target #(
        .BASE_ADDR(BASE),
        .ADDR_MASK(MASK),
        .TIMEOUT  (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .aen      (aen),
        .size     (size),
        .wr_n     (wr_n),
        .AD_in    (AD_in),
        .AD_out   (AD_out),
        .ad_oe    (ad_oe),
        .rdy_n    (rdy_n),
        .error_n  (error_n),
        .irq_n    (irq_n),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_be   (bus_be),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Transaction-level expectation: frame A0 is cycle 0, response follows the
    // decode cycle (miss) or the ack / timeout cycle of the backend access.
    function automatic exp_t model(input logic [31:0] addr, input logic we, input logic sz,
                                   input int ack_at, input logic [15:0] rd, input logic berr);
        exp_t e;
        e.be = sz ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
        if ((addr & MASK) != BASE) begin
            e.req_cnt = 0; e.rdy_cyc = 3; e.errn = 1'b0;
        end else if (ack_at >= 1 && ack_at <= TMO) begin
            e.req_cnt = ack_at; e.rdy_cyc = 3 + ack_at; e.errn = ~berr;
        end else begin
            e.req_cnt = TMO; e.rdy_cyc = 3 + TMO; e.errn = 1'b0;
        end
        e.oe = ~we;
        e.ad = (we || !e.errn) ? 16'h0000 : rd;
        return e;
    endfunction

    // Drives one full bridge transaction and records what the endpoint did.
    // ack_at = WAIT cycle (1-based) in which bus_ack pulses; 0 = never.
    task automatic run_xfer(input logic [31:0] addr, input logic we, input logic sz,
                            input logic [15:0] wd, input int ack_at, input logic [15:0] rd,
                            input logic berr, output obs_t o);
        o = '{rdy_cyc: -1, rdy_cnt: 0, req_cnt: 0, req_first: -1, ad: '0, oe: 1'b0,
              errn: 1'b1, ba: '0, be: '0, bwe: 1'b0, bwd: '0, unstable: 0, idle_bad: 0};
        for (int c = 0; c <= NCYC; c++) begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                o.req_cnt++;
                if (o.req_first < 0) begin
                    o.req_first = c; o.ba = bus_addr; o.be = bus_be; o.bwe = bus_we; o.bwd = bus_wdata;
                end else if (bus_addr !== o.ba || bus_be !== o.be || bus_we !== o.bwe || bus_wdata !== o.bwd) begin
                    o.unstable++;
                end
            end
            if (rdy_n === 1'b0) begin
                o.rdy_cnt++;
                if (o.rdy_cyc < 0) begin
                    o.rdy_cyc = c; o.ad = AD_out; o.oe = ad_oe; o.errn = error_n;
                end
            end else if (ad_oe !== 1'b0 || error_n !== 1'b1 || AD_out !== 16'h0000) begin
                o.idle_bad++;
            end
            case (c)
                0: begin aen = 1'b1; AD_in = addr[15:0]; wr_n = we; size = sz; end
                1: begin aen = 1'b1; AD_in = addr[31:16]; wr_n = $urandom; size = $urandom; end
                2: begin aen = 1'b0; AD_in = we ? wd : 16'(($urandom)); end
                default: begin aen = 1'b0; AD_in = 16'($urandom); end
            endcase
            bus_ack   = (ack_at > 0 && c == 2 + ack_at);
            bus_rdata = bus_ack ? rd : 16'($urandom);
            bus_err   = bus_ack ? berr : 1'($urandom);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rdy_n, error_n, irq_n, ad_oe, AD_out} !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_resp: got %b_%b_%b_%b_%h expected 1_1_1_0_0000", rdy_n, error_n, irq_n, ad_oe, AD_out);
        end
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b0, 1'b0, 32'h0, 2'b00, 16'h0}) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h expected all zero", bus_req, bus_we, bus_addr, bus_be, bus_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        obs_t o;
        run_xfer(32'h0000_0010, 1'b0, 1'b1, 16'h0, 1, 16'hBEEF, 1'b0, o);
        checks++;
        if (o.rdy_cyc !== 4 || o.rdy_cnt !== 1) begin
            errors++; $display("FAIL read_latency: got cycle %0d count %0d expected cycle 4 count 1", o.rdy_cyc, o.rdy_cnt);
        end
        checks++;
        if (o.ad !== 16'hBEEF || o.oe !== 1'b1 || o.errn !== 1'b1) begin
            errors++; $display("FAIL read_data: got ad=%h oe=%b errn=%b expected beef 1 1", o.ad, o.oe, o.errn);
        end
        checks++;
        if (o.ba !== 32'h0000_0010 || o.be !== 2'b11 || o.bwe !== 1'b0 || o.req_cnt !== 1) begin
            errors++; $display("FAIL read_bus: got addr=%h be=%b we=%b req=%0d expected 00000010 11 0 1", o.ba, o.be, o.bwe, o.req_cnt);
        end
    endtask

    task automatic test_write_byte();
        obs_t o;
        run_xfer(32'h0000_0023, 1'b1, 1'b0, 16'hAB00, 5, 16'h1234, 1'b0, o);
        checks++;
        if (o.bwe !== 1'b1 || o.be !== 2'b10 || o.bwd !== 16'hAB00 || o.ba !== 32'h0000_0023) begin
            errors++; $display("FAIL wbyte_bus: got we=%b be=%b wdata=%h addr=%h expected 1 10 ab00 00000023", o.bwe, o.be, o.bwd, o.ba);
        end
        checks++;
        if (o.req_cnt !== 5 || o.unstable !== 0) begin
            errors++; $display("FAIL wbyte_req: got req cycles %0d unstable %0d expected 5 0", o.req_cnt, o.unstable);
        end
        checks++;
        if (o.rdy_cnt !== 1 || o.rdy_cyc !== 8 || o.errn !== 1'b1 || o.oe !== 1'b0) begin
            errors++; $display("FAIL wbyte_resp: got count %0d cycle %0d errn %b oe %b expected 1 8 1 0", o.rdy_cnt, o.rdy_cyc, o.errn, o.oe);
        end
    endtask

    task automatic test_miss();
        obs_t o;
        for (int w = 0; w < 2; w++) begin
            run_xfer(32'h0001_0000, 1'(w), 1'b1, 16'h5A5A, 1, 16'hFFFF, 1'b0, o);
            checks++;
            if (o.req_cnt !== 0 || o.rdy_cyc !== 3 || o.rdy_cnt !== 1 || o.errn !== 1'b0 || o.ad !== 16'h0) begin
                errors++;
                $display("FAIL miss[we=%0d]: got req=%0d cycle=%0d count=%0d errn=%b ad=%h expected 0 3 1 0 0000", w, o.req_cnt, o.rdy_cyc, o.rdy_cnt, o.errn, o.ad);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        // no ack, then an ack arriving one cycle after bus_req has dropped
        for (int k = 0; k < 2; k++) begin
            run_xfer(32'h0000_0100, 1'b0, 1'b1, 16'h0, (k == 0) ? 0 : TMO + 1, 16'hC0DE, 1'b0, o);
            checks++;
            if (o.req_cnt !== TMO || o.rdy_cyc !== 3 + TMO || o.rdy_cnt !== 1 || o.errn !== 1'b0 || o.ad !== 16'h0) begin
                errors++;
                $display("FAIL timeout[%0d]: got req=%0d cycle=%0d count=%0d errn=%b ad=%h expected %0d %0d 1 0 0000", k, o.req_cnt, o.rdy_cyc, o.rdy_cnt, o.errn, o.ad, TMO, 3 + TMO);
            end
        end
        run_xfer(32'h0000_0100, 1'b0, 1'b1, 16'h0, TMO, 16'hC0DE, 1'b0, o);
        checks++;
        if (o.req_cnt !== TMO || o.rdy_cyc !== 3 + TMO || o.errn !== 1'b1 || o.ad !== 16'hC0DE) begin
            errors++;
            $display("FAIL ack_at_limit: got req=%0d cycle=%0d errn=%b ad=%h expected %0d %0d 1 c0de", o.req_cnt, o.rdy_cyc, o.errn, o.ad, TMO, 3 + TMO);
        end
    endtask

    task automatic test_abort();
        obs_t o;
        int   req_seen = 0;
        int   rdy_seen = 0;
        @(negedge clk);
        aen = 1'b1; AD_in = 16'h0010; wr_n = 1'b0; size = 1'b1;
        @(negedge clk);
        aen = 1'b0; AD_in = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_req !== 1'b0) req_seen++;
            if (rdy_n !== 1'b1) rdy_seen++;
        end
        checks++;
        if (req_seen !== 0 || rdy_seen !== 0) begin
            errors++; $display("FAIL abort: got req cycles %0d rdy cycles %0d expected 0 0", req_seen, rdy_seen);
        end
        run_xfer(32'h0000_0010, 1'b0, 1'b1, 16'h0, 1, 16'h7E57, 1'b0, o);
        checks++;
        if (o.rdy_cyc !== 4 || o.ad !== 16'h7E57 || o.errn !== 1'b1) begin
            errors++; $display("FAIL after_abort: got cycle %0d ad %h errn %b expected 4 7e57 1", o.rdy_cyc, o.ad, o.errn);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   req_seen = 0;
        int   rdy_seen = 0;
        @(negedge clk);
        aen = 1'b1; AD_in = 16'h0040; wr_n = 1'b0; size = 1'b1;
        @(negedge clk);
        AD_in = 16'h0000;
        @(negedge clk);
        aen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got bus_req %b expected 1", bus_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0 || rdy_n !== 1'b1 || error_n !== 1'b1 || ad_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got req=%b rdy_n=%b error_n=%b ad_oe=%b expected 0 1 1 0", bus_req, rdy_n, error_n, ad_oe);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_req !== 1'b0) req_seen++;
            if (rdy_n !== 1'b1) rdy_seen++;
        end
        checks++;
        if (req_seen !== 0 || rdy_seen !== 0) begin
            errors++; $display("FAIL rst_mid_quiet: got req cycles %0d rdy cycles %0d expected 0 0", req_seen, rdy_seen);
        end
        run_xfer(32'h0000_0041, 1'b1, 1'b0, 16'h0033, 2, 16'h0, 1'b0, o);
        checks++;
        if (o.rdy_cyc !== 5 || o.errn !== 1'b1 || o.be !== 2'b10 || o.bwd !== 16'h0033) begin
            errors++; $display("FAIL rst_mid_after: got cycle %0d errn %b be %b wdata %h expected 5 1 10 0033", o.rdy_cyc, o.errn, o.be, o.bwd);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] addr;
        logic        we, sz, berr;
        logic [15:0] wd, rd;
        int          ack_at;
        for (int i = 0; i < 30; i++) begin
            addr   = ($urandom_range(0, 3) == 0) ? $urandom : {16'h0000, 16'($urandom)};
            we     = $urandom; sz = $urandom; berr = ($urandom_range(0, 3) == 0);
            wd     = $urandom; rd = $urandom;
            ack_at = $urandom_range(0, TMO + 2);
            e = model(addr, we, sz, ack_at, rd, berr);
            run_xfer(addr, we, sz, wd, ack_at, rd, berr, o);
            checks++;
            if (o.rdy_cyc !== e.rdy_cyc || o.rdy_cnt !== 1) begin
                errors++; $display("FAIL rand[%0d] rdy: got cycle %0d count %0d expected %0d 1", i, o.rdy_cyc, o.rdy_cnt, e.rdy_cyc);
            end
            checks++;
            if (o.ad !== e.ad || o.oe !== e.oe || o.errn !== e.errn) begin
                errors++; $display("FAIL rand[%0d] resp: got ad=%h oe=%b errn=%b expected %h %b %b", i, o.ad, o.oe, o.errn, e.ad, e.oe, e.errn);
            end
            checks++;
            if (o.req_cnt !== e.req_cnt || o.idle_bad !== 0) begin
                errors++; $display("FAIL rand[%0d] req: got req cycles %0d idle glitches %0d expected %0d 0", i, o.req_cnt, o.idle_bad, e.req_cnt);
            end
            if (e.req_cnt > 0) begin
                checks++;
                if (o.req_first !== 3 || o.ba !== addr || o.be !== e.be || o.bwe !== we || o.unstable !== 0 || (we && o.bwd !== wd)) begin
                    errors++;
                    $display("FAIL rand[%0d] bus: got first=%0d addr=%h be=%b we=%b wdata=%h unstable=%0d expected 3 %h %b %b %h 0", i, o.req_first, o.ba, o.be, o.bwe, o.bwd, o.unstable, addr, e.be, we, wd);
                end
            end
        end
    endtask

    task automatic test_irq();
        logic last = 1'b0;
        logic v;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (irq_n !== ~last) begin
                errors++; $display("FAIL irq_follow[%0d]: got irq_n %b expected %b", i, irq_n, ~last);
            end
            v = (i % 3 == 2) ? last : ~last;
            if (i > 8) v = 1'($urandom);
            irq = v;
            #1;
            checks++;
            if (irq_n !== ~last) begin
                errors++; $display("FAIL irq_latency[%0d]: got irq_n %b expected %b", i, irq_n, ~last);
            end
            last = v;
        end
        @(negedge clk);
        irq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; aen = 1'b0; size = 1'b0; wr_n = 1'b0; AD_in = '0;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0; irq = 1'b0;
        test_reset();
        test_read();
        test_write_byte();
        test_miss();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
